// File: rtl/bist_session_sequencer.sv
// bist_session_sequencer
//
// Multi-session BIST scheduler. A rising edge on START runs N_SESSIONS
// sessions back-to-back. Each session loads the LFSR seed/polynomial for
// SESSION and clears the MISR (LOAD). It then clocks N_PATTERNS patterns
// (RUN), absorbs the last response (FLUSH) and compares the MISR signature
// with the golden signature (CHECK). The block reports an aggregate PASS and
// the index of the first failing session.
//
// Optional build macro: BIST_EARLY_ABORT_EN
//   defined   -> the first mismatching CHECK goes straight to DONE.
//   undefined -> every session always runs and the run time is fixed.
//
// Ports
//   CLK          in   clock, all logic on the rising edge
//   RESET        in   synchronous active-high reset
//   START        in   run request, acted on only on a low->high transition
//   MISR_SIG     in   current MISR signature
//   GOLDEN_SIG   in   golden signature for SESSION (combinational lookup)
//   SESSION      out  current session index (seed/poly/golden select)
//   LOAD_SEED    out  one-cycle strobe: LFSR loads seed/poly for SESSION
//   MISR_CLR     out  one-cycle strobe: clear MISR (coincident with LOAD_SEED)
//   LFSR_EN      out  LFSR advance enable
//   MISR_EN      out  MISR compaction enable
//   BIST_END     out  run complete, held high in DONE
//   PASS         out  valid with BIST_END; 1 = every run session matched
//   FAIL_SESSION out  index of the first mismatching session, 0 if none
module bist_session_sequencer #(
    parameter int N_SESSIONS = 2,
    parameter int N_PATTERNS = 16,
    parameter int SIG_W      = 8,
    parameter int CNT_W      = 16,
    parameter int SES_W      = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [SIG_W-1:0] MISR_SIG,
    input  logic [SIG_W-1:0] GOLDEN_SIG,
    output logic [SES_W-1:0] SESSION,
    output logic             LOAD_SEED,
    output logic             MISR_CLR,
    output logic             LFSR_EN,
    output logic             MISR_EN,
    output logic             BIST_END,
    output logic             PASS,
    output logic [SES_W-1:0] FAIL_SESSION
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);
    localparam logic [SES_W-1:0] LAST_SES = SES_W'(N_SESSIONS - 1);

    logic [2:0]       state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SES_W-1:0] ses_q, ses_d;
    logic             fail_q, fail_d;
    logic [SES_W-1:0] fail_ses_q, fail_ses_d;
    logic             start_rise;
    logic             mismatch;

    assign start_rise = START & ~start_q;
    assign mismatch   = (MISR_SIG != GOLDEN_SIG);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ses_d      = ses_q;
        fail_d     = fail_q;
        fail_ses_d = fail_ses_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // Start and restart both begin a fresh run from session 0.
                if (start_rise) begin
                    state_d    = S_LOAD;
                    ses_d      = '0;
                    fail_d     = 1'b0;
                    fail_ses_d = '0;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Only the first failing session is recorded.
                if (mismatch && !fail_q) begin
                    fail_d     = 1'b1;
                    fail_ses_d = ses_q;
                end
`ifdef BIST_EARLY_ABORT_EN
                if (mismatch || (ses_q == LAST_SES)) begin
                    state_d = S_DONE;
                end else begin
                    ses_d   = ses_q + SES_W'(1);
                    state_d = S_LOAD;
                end
`else
                if (ses_q == LAST_SES) begin
                    state_d = S_DONE;
                end else begin
                    ses_d   = ses_q + SES_W'(1);
                    state_d = S_LOAD;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            // Reset to 1 so a START held high through reset is not an edge.
            start_q    <= 1'b1;
            cnt_q      <= '0;
            ses_q      <= '0;
            fail_q     <= 1'b0;
            fail_ses_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= START;
            cnt_q      <= cnt_d;
            ses_q      <= ses_d;
            fail_q     <= fail_d;
            fail_ses_q <= fail_ses_d;
        end
    end

    assign SESSION      = ses_q;
    assign LOAD_SEED    = (state_q == S_LOAD);
    assign MISR_CLR     = (state_q == S_LOAD);
    assign LFSR_EN      = (state_q == S_RUN);
    assign MISR_EN      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign BIST_END     = (state_q == S_DONE);
    assign PASS         = (state_q == S_DONE) && !fail_q;
    assign FAIL_SESSION = fail_ses_q;

endmodule

// File: tb/tb_bist_session_sequencer.sv
module tb_bist_session_sequencer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] MISR_SIG;
    logic [7:0] GOLDEN_SIG;
    logic [1:0] SESSION;
    logic       LOAD_SEED;
    logic       MISR_CLR;
    logic       LFSR_EN;
    logic       MISR_EN;
    logic       BIST_END;
    logic       PASS;
    logic [1:0] FAIL_SESSION;

    logic [7:0] gold_tab [4];
    logic [7:0] misr_tab [4];

    int vectors;
    int miscompares;

    typedef struct {
        int done_cyc;
        int pass;
        int fs;
        int ses;
        int loads;
        int l1;
    } exp_t;

    exp_t sb [$];

    bist_session_sequencer #(
        .N_SESSIONS(2),
        .N_PATTERNS(4),
        .SIG_W     (8),
        .CNT_W     (16),
        .SES_W     (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .MISR_SIG    (MISR_SIG),
        .GOLDEN_SIG  (GOLDEN_SIG),
        .SESSION     (SESSION),
        .LOAD_SEED   (LOAD_SEED),
        .MISR_CLR    (MISR_CLR),
        .LFSR_EN     (LFSR_EN),
        .MISR_EN     (MISR_EN),
        .BIST_END    (BIST_END),
        .PASS        (PASS),
        .FAIL_SESSION(FAIL_SESSION)
    );

    // External ROM / MISR stand-ins, indexed by the DUT's session select.
    assign GOLDEN_SIG = gold_tab[SESSION];
    assign MISR_SIG   = misr_tab[SESSION];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one START edge, follows the run to BIST_END and checks it
    // against the expectation queued before the stimulus.
    task automatic run_check(input string name, input exp_t e, input bit toggle);
        int   rel, loads, lfsr, men, l0, l1, ses_l0, bad, last_pass;
        bit   done;
        exp_t x;
        rel = 0; loads = 0; lfsr = 0; men = 0; l0 = 0; l1 = 0;
        ses_l0 = 0; bad = 0; done = 0;
        sb.push_back(e);
        START = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1;
        @(posedge CLK); #1;
        rel = 1;
        for (int i = 0; i < 60; i++) begin
            if (BIST_END === 1'b1) begin
                done = 1;
                break;
            end
            if (LOAD_SEED === 1'b1) begin
                loads++;
                if (loads == 1) begin
                    l0 = rel;
                    ses_l0 = SESSION;
                end else if (loads == 2) begin
                    l1 = rel;
                end
            end
            if (LFSR_EN === 1'b1) lfsr++;
            if (MISR_EN === 1'b1) men++;
            if (MISR_CLR !== LOAD_SEED || PASS !== 1'b0 || (LFSR_EN && !MISR_EN)) bad++;
            START = toggle && (rel == 3 || rel == 10);
            @(posedge CLK); #1;
            rel++;
        end
        chk({name, "_reached_done"}, done, 1);
        x = sb.pop_front();
        chk({name, "_done_cycle"}, rel, x.done_cyc);
        chk({name, "_pass"}, PASS, x.pass);
        chk({name, "_fail_session"}, FAIL_SESSION, x.fs);
        chk({name, "_session"}, SESSION, x.ses);
        chk({name, "_load_count"}, loads, x.loads);
        chk({name, "_load0_cycle"}, l0, 1);
        chk({name, "_load1_cycle"}, l1, x.l1);
        chk({name, "_load0_session"}, ses_l0, 0);
        chk({name, "_lfsr_cycles"}, lfsr, 4 * x.loads);
        chk({name, "_misr_cycles"}, men, 5 * x.loads);
        chk({name, "_strobe_rules"}, bad, 0);
        last_pass = PASS;
        @(posedge CLK); #1;
        chk({name, "_done_hold"}, {BIST_END, PASS}, {1'b1, last_pass[0]});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4; i++) begin
            gold_tab[i] = 8'h3C + 8'(i);
            misr_tab[i] = 8'h3C + 8'(i);
        end

        // Reset with START held high.
        RESET = 1'b1;
        START = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs",
            {LOAD_SEED, MISR_CLR, LFSR_EN, MISR_EN, BIST_END, PASS, SESSION, FAIL_SESSION}, 0);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("start_held_idle", {LOAD_SEED, LFSR_EN, MISR_EN, BIST_END}, 0);

        // All sessions match.
        run_check("all_match", '{15, 1, 0, 1, 2, 8}, 1'b0);

        // Session 0 mismatch (restart from DONE, PASS recomputed).
        gold_tab[0] = 8'hA5;
        misr_tab[0] = 8'h5A;
`ifdef BIST_EARLY_ABORT_EN
        run_check("ses0_fail", '{8, 0, 0, 0, 1, 0}, 1'b0);
`else
        run_check("ses0_fail", '{15, 0, 0, 1, 2, 8}, 1'b0);
`endif

        // Only session 1 mismatches.
        gold_tab[0] = 8'h3C;
        misr_tab[0] = 8'h3C;
        misr_tab[1] = 8'hC3;
        run_check("ses1_fail", '{15, 0, 1, 1, 2, 8}, 1'b0);

        // START toggled during RUN of both sessions is ignored.
        misr_tab[1] = 8'h3D;
        run_check("start_toggle", '{15, 1, 0, 1, 2, 8}, 1'b1);

        // Both sessions mismatch: the first one is kept.
        misr_tab[0] = 8'h00;
        misr_tab[1] = 8'hFF;
`ifdef BIST_EARLY_ABORT_EN
        run_check("both_fail", '{8, 0, 0, 0, 1, 0}, 1'b0);
`else
        run_check("both_fail", '{15, 0, 0, 1, 2, 8}, 1'b0);
`endif

        // Reset for one cycle during session 1 RUN.
        misr_tab[0] = 8'h3C;
        misr_tab[1] = 8'h3D;
        START = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        chk("midrun_in_run", {LFSR_EN, SESSION}, {1'b1, 2'd1});
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midrun_reset_outputs",
            {LOAD_SEED, MISR_CLR, LFSR_EN, MISR_EN, BIST_END, PASS, SESSION, FAIL_SESSION}, 0);
        RESET = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("midrun_stays_idle", {LOAD_SEED, LFSR_EN, MISR_EN, BIST_END}, 0);
        run_check("after_reset", '{15, 1, 0, 1, 2, 8}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
